// File: rtl/piso_pkg.sv
// Shared definitions for the PISO error-count readout sequencer.
package piso_pkg;

  localparam int PISO_NUM_CH = 10;
  localparam int PISO_WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } piso_state_t;

  // LSB position of channel c inside the flattened readout bus
  function automatic int ch_lsb(input int c, input int word_w);
    return c * word_w;
  endfunction

endpackage

// File: rtl/piso_sclk_gen.sv
// Divided shift-clock generator: CLK_DIV cycles low, then CLK_DIV cycles high, per period.
module piso_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic sample_stb,
  output logic period_end
);

  localparam int CNT_W = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] HALF      = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(2 * CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             run;

  // en describes the coming cycle, so the first enabled cycle starts at count 0
  always_comb begin
    cnt_nxt = '0;
    if (en && run && (cnt != PER_LAST)) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      run  <= 1'b0;
      sclk <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      run  <= en;
      sclk <= en && (cnt_nxt >= HALF);
    end
  end

  assign sample_stb = run && (cnt == HALF_LAST);
  assign period_end = run && (cnt == PER_LAST);

endmodule

// File: rtl/piso_readout_ctrl.sv
// Sequences load/shift of the testchip PISO error counters and assembles one word per channel.
module piso_readout_ctrl
  import piso_pkg::*;
#(
  parameter int NUM_CH  = PISO_NUM_CH,
  parameter int WORD_W  = PISO_WORD_W,
  parameter int CLK_DIV = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [NUM_CH-1:0]        q_i,
  output logic                     chip_load_o,
  output logic                     chip_sclk_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [NUM_CH*WORD_W-1:0] data_o
);

  localparam int BIT_W = $clog2(WORD_W + 1);
  localparam int IDX_W = $clog2(WORD_W);

  piso_state_t       state;
  piso_state_t       state_nxt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [WORD_W-1:0] shadow [NUM_CH];
  logic              sclk_en;
  logic              sample_stb;
  logic              period_end;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = LOAD;
      LOAD: begin
        if (abort_i)         state_nxt = IDLE;
        else if (period_end) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (abort_i) state_nxt = IDLE;
        else if (period_end && (bit_cnt == BIT_W'(WORD_W - 1))) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Driven from the next state so an abort stops the shift clock on the same edge
  assign sclk_en = (state_nxt == LOAD) || (state_nxt == SHIFT);
  assign busy_o  = (state == LOAD) || (state == SHIFT);
  assign bit_idx = bit_cnt[IDX_W-1:0];

  piso_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (sclk_en),
    .sclk      (chip_sclk_o),
    .sample_stb(sample_stb),
    .period_end(period_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      chip_load_o <= 1'b0;
      done_o      <= 1'b0;
      data_o      <= '0;
    end else begin
      state       <= state_nxt;
      chip_load_o <= (state_nxt == LOAD);
      done_o      <= (state_nxt == DONE);
      if ((state_nxt == LOAD) && (state != LOAD)) begin
        bit_cnt <= '0;
      end else if ((state == SHIFT) && period_end) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      // Publish on the edge into DONE so data_o and done_o change together
      if (state_nxt == DONE) begin
        for (int c = 0; c < NUM_CH; c++) begin
          data_o[ch_lsb(c, WORD_W) +: WORD_W] <= shadow[c];
        end
      end
    end
  end

  // Shift data is captured at the end of the low half, after a full half-period to settle
  always_ff @(posedge clk) begin
    if ((state == SHIFT) && sample_stb) begin
      for (int c = 0; c < NUM_CH; c++) begin
        shadow[c][bit_idx] <= q_i[c];
      end
    end
  end

endmodule

// File: tb/tb_piso_readout_ctrl.sv
// Scoreboard bench for piso_readout_ctrl: one instance at CLK_DIV=4, one at CLK_DIV=1.
module tb_piso_readout_ctrl;

  localparam int NCH = 10;
  localparam int WW  = 16;
  localparam int DW  = NCH * WW;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
  logic [NCH-1:0] q0, q1;
  logic          load0, sclk0, busy0, done0;
  logic          load1, sclk1, busy1, done1;
  logic [DW-1:0] data0, data1;

  piso_readout_ctrl #(.NUM_CH(NCH), .WORD_W(WW), .CLK_DIV(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start0), .abort_i(abort0), .q_i(q0),
    .chip_load_o(load0), .chip_sclk_o(sclk0), .busy_o(busy0), .done_o(done0), .data_o(data0)
  );

  piso_readout_ctrl #(.NUM_CH(NCH), .WORD_W(WW), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .abort_i(abort1), .q_i(q1),
    .chip_load_o(load1), .chip_sclk_o(sclk1), .busy_o(busy1), .done_o(done1), .data_o(data1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Chip model: counters captured on a rising shift clock while load is high, else shift right
  logic [WW-1:0] cv0 [NCH];
  logic [WW-1:0] cv1 [NCH];
  logic [WW-1:0] sr0 [NCH];
  logic [WW-1:0] sr1 [NCH];
  int nedge0 = 0;

  always @(posedge sclk0) begin
    nedge0 = nedge0 + 1;
    for (int c = 0; c < NCH; c++) sr0[c] <= load0 ? cv0[c] : (sr0[c] >> 1);
  end

  always @(posedge sclk1) begin
    for (int c = 0; c < NCH; c++) sr1[c] <= load1 ? cv1[c] : (sr1[c] >> 1);
  end

  always_comb begin
    q0 = '0;
    q1 = '0;
    for (int c = 0; c < NCH; c++) begin
      q0[c] = sr0[c][0];
      q1[c] = sr1[c][0];
    end
  end

  exp_t sb0[$];
  exp_t sb1[$];

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done0) begin
      if (sb0.size() == 0) check_int("done0_unexpected", sb0.size(), 1);
      else begin
        e = sb0.pop_front();
        check_data("data0", data0, e.data);
        check_int("done0_cycle", cyc, e.cyc);
      end
    end
    if (rst_n && done1) begin
      if (sb1.size() == 0) check_int("done1_unexpected", sb1.size(), 1);
      else begin
        e = sb1.pop_front();
        check_data("data1", data1, e.data);
        check_int("done1_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [DW-1:0] pack0();
    logic [DW-1:0] d;
    for (int c = 0; c < NCH; c++) d[c*WW +: WW] = cv0[c];
    return d;
  endfunction

  function automatic logic [DW-1:0] pack1();
    logic [DW-1:0] d;
    for (int c = 0; c < NCH; c++) d[c*WW +: WW] = cv1[c];
    return d;
  endfunction

  // Full readout on unit u; returns in the cycle after DONE, the earliest legal next start
  task automatic readout(input int u, input bit expect_done);
    exp_t e;
    int   d;
    d     = (u == 0) ? 4 : 1;
    e.cyc = cyc + 2 * d * (WW + 1) + 1;
    e.data = (u == 0) ? pack0() : pack1();
    if (expect_done) begin
      if (u == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
    if (u == 0) start0 = 1'b1; else start1 = 1'b1;
    tick(1);
    start0 = 1'b0;
    start1 = 1'b0;
    tick(2 * d * (WW + 1));
    tick(1);
  endtask

  logic [DW-1:0] pat1234;
  int            n_before;

  initial begin
    for (int c = 0; c < NCH; c++) begin
      cv0[c] = '0;
      cv1[c] = '0;
      pat1234[c*WW +: WW] = 16'h1234;
    end
    tick(3);
    check_bit("rst_busy0", busy0, 1'b0);
    check_bit("rst_load0", load0, 1'b0);
    check_bit("rst_sclk0", sclk0, 1'b0);
    check_bit("rst_done0", done0, 1'b0);
    check_data("rst_data0", data0, '0);
    check_data("rst_data1", data1, '0);
    rst_n = 1'b1;
    tick(2);

    // Single readout with the reference counter values
    cv0[0] = 16'hA5C3;
    cv0[9] = 16'h0001;
    for (int c = 1; c <= 8; c++) cv0[c] = 16'(c);
    n_before = nedge0;
    readout(0, 1'b1);
    check_int("sclk_rises", nedge0 - n_before, 17);

    // Start while busy (cycle 50) and in the DONE cycle (137) must be ignored
    for (int c = 0; c < NCH; c++) cv0[c] = 16'($urandom);
    begin
      exp_t e;
      e.cyc  = cyc + 137;
      e.data = pack0();
      sb0.push_back(e);
    end
    start0 = 1'b1; tick(1); start0 = 1'b0;
    tick(1);
    check_bit("load_in_load", load0, 1'b1);
    check_bit("sclk_low_c2", sclk0, 1'b0);
    tick(48);
    check_bit("busy_c50", busy0, 1'b1);
    start0 = 1'b1; tick(1); start0 = 1'b0;
    tick(86);
    start0 = 1'b1; tick(1); start0 = 1'b0;
    check_bit("busy_after_done", busy0, 1'b0);
    tick(150);
    check_bit("idle_after_ignored", busy0, 1'b0);

    // Abort at bit 7 keeps the previous words
    for (int c = 0; c < NCH; c++) cv0[c] = 16'h1234;
    readout(0, 1'b1);
    for (int c = 0; c < NCH; c++) cv0[c] = 16'($urandom);
    start0 = 1'b1; tick(1); start0 = 1'b0;
    tick(65);
    abort0 = 1'b1; tick(1); abort0 = 1'b0;
    check_bit("abort_busy", busy0, 1'b0);
    check_bit("abort_sclk", sclk0, 1'b0);
    check_bit("abort_load", load0, 1'b0);
    check_data("abort_data", data0, pat1234);
    tick(160);
    check_data("abort_data_later", data0, pat1234);

    // Asynchronous reset at bit 7
    for (int c = 0; c < NCH; c++) cv0[c] = 16'($urandom) | 16'h0100;
    readout(0, 1'b1);
    start0 = 1'b1; tick(1); start0 = 1'b0;
    tick(65);
    check_bit("pre_reset_busy", busy0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_bit("arst_busy", busy0, 1'b0);
    check_bit("arst_load", load0, 1'b0);
    check_bit("arst_sclk", sclk0, 1'b0);
    check_bit("arst_done", done0, 1'b0);
    check_data("arst_data", data0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check_bit("post_rst_busy", busy0, 1'b0);
    check_data("post_rst_data", data0, '0);

    // Back-to-back on the CLK_DIV=1 unit
    for (int c = 0; c < NCH; c++) cv1[c] = 16'hFFFF;
    readout(1, 1'b1);
    for (int c = 0; c < NCH; c++) cv1[c] = 16'h0000;
    readout(1, 1'b1);

    // Walking one: readout k sets only bit k on channel k mod 10
    for (int k = 0; k < WW; k++) begin
      for (int c = 0; c < NCH; c++) cv1[c] = '0;
      cv1[k % NCH] = 16'd1 << k;
      readout(1, 1'b1);
    end

    // Random counter values on both units
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NCH; c++) cv0[c] = 16'($urandom);
      readout(0, 1'b1);
    end
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < NCH; c++) cv1[c] = 16'($urandom);
      readout(1, 1'b1);
    end

    tick(5);
    check_int("sb0_drained", sb0.size(), 0);
    check_int("sb1_drained", sb1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
